// File: rtl/pulse_sync_rx_pkg.sv
// Shared types and helpers for the toggle-based pulse-crossing receiver.
// FSM encodings and seed-length derivation live here so top and bench agree.
package pulse_sync_rx_pkg;

   typedef enum logic {
      ST_SEED = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Seed counter must hold seed_len(4)-1 = 4 at the largest legal chain depth.
   localparam int SEED_CNT_W = 3;

   // Cycles spent in SEED: the chain must fill before its output is trusted.
   function automatic int seed_len(input int stages);
      return stages + 1;
   endfunction

endpackage

// File: rtl/pulse_sync_rx_sync_ff_chain.sv
// Plain asynchronous-input synchroniser: STAGES flops, no other logic.
// Latency STAGES cycles; no backpressure.
module sync_ff_chain #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_sync_rx.sv
// Toggle-crossing receiver: sync, edge-to-pulse, saturating event queue, ack toggle.
// Pulse/count update SYNC_STAGES cycles after tog_in is sampled; consumer pops via evt_valid/evt_ready.
module pulse_sync_rx
   import pulse_sync_rx_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 4
) (
   input  logic             clk_out,
   input  logic             rst_n,
   input  logic             tog_in,
   output logic             ack_tog,
   output logic             pulse_out,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [CNT_W-1:0] evt_cnt,
   output logic             ovf,
   input  logic             clr_ovf
);

   localparam logic [SEED_CNT_W-1:0] SEED_LAST = SEED_CNT_W'(seed_len(SYNC_STAGES) - 1);
   localparam logic [CNT_W-1:0]      CNT_MAX   = '1;

   logic                  tog_sync;
   state_e                state_q, state_d;
   logic [SEED_CNT_W-1:0] seed_cnt_q, seed_cnt_d;
   logic                  ref_q, ref_d;
   logic                  ack_q, ack_d;
   logic                  pulse_q, pulse_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  ovf_q, ovf_d;
   logic                  arrive;
   logic                  pop;
   logic                  ovf_set;

   sync_ff_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i  (clk_out),
      .rst_ni (rst_n),
      .d_i    (tog_in),
      .q_o    (tog_sync)
   );

   always_ff @(posedge clk_out or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_SEED;
         seed_cnt_q <= '0;
         ref_q      <= 1'b0;
         ack_q      <= 1'b0;
         pulse_q    <= 1'b0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         seed_cnt_q <= seed_cnt_d;
         ref_q      <= ref_d;
         ack_q      <= ack_d;
         pulse_q    <= pulse_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      seed_cnt_d = seed_cnt_q;
      ref_d      = ref_q;
      ack_d      = ack_q;
      pulse_d    = 1'b0;
      arrive     = 1'b0;
      unique case (state_q)
         // Adopt whatever level the sender left behind without raising an event.
         ST_SEED: begin
            if (seed_cnt_q == SEED_LAST) begin
               ref_d   = tog_sync;
               ack_d   = tog_sync;
               state_d = ST_RUN;
            end else begin
               seed_cnt_d = seed_cnt_q + SEED_CNT_W'(1);
            end
         end
         ST_RUN: begin
            if (tog_sync != ref_q) begin
               ref_d   = tog_sync;
               ack_d   = tog_sync;
               pulse_d = 1'b1;
               arrive  = 1'b1;
            end
         end
         default: state_d = ST_SEED;
      endcase
   end

   assign pop = evt_ready && (cnt_q != '0);

   always_comb begin
      cnt_d   = cnt_q;
      ovf_set = 1'b0;
      if (arrive && !pop) begin
         if (cnt_q == CNT_MAX) begin
            ovf_set = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (pop && !arrive) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      // A fresh overflow beats a simultaneous clear.
      ovf_d = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
   end

   assign ack_tog   = ack_q;
   assign pulse_out = pulse_q;
   assign evt_cnt   = cnt_q;
   assign evt_valid = (cnt_q != '0);
   assign ovf       = ovf_q;

endmodule
